// File: rtl/amba_memory_master.sv
// AXI4-Lite style single-outstanding initiator bridging a simple CPU load/store
// request port onto AW/W/B/AR/R channels, with a per-phase watchdog.
module amba_memory_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [2:0]  PROT_VAL       = 3'b000
) (
  input  logic                ACLK,
  input  logic                reset,
  // CPU request side
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                req_ready,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_code,
  output logic                timeout,
  // write address channel
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  // write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  // write response channel
  input  logic                BVALID,
  input  logic [1:0]          BRESP,
  output logic                BREADY,
  // read address channel
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  // read data channel
  input  logic                RVALID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  output logic                RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          code_q, code_d;
  logic                resp_valid_q, resp_valid_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                aw_hs_c, w_hs_c, wd_fire_c, abort_c;

  // Next-state and next-output computation for every registered signal
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    code_d       = code_q;
    resp_valid_d = 1'b0;
    timeout_d    = 1'b0;
    cnt_d        = cnt_q;
    abort_c      = 1'b0;

    aw_hs_c   = awvalid_q & AWREADY;
    w_hs_c    = wvalid_q & WREADY;
    wd_fire_c = WD_EN && (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          if (req_write) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      S_WADDR: begin
        if (aw_hs_c) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs_c) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WRESP;
        end else if (wd_fire_c) begin
          abort_c = 1'b1;
        end
      end

      S_WRESP: begin
        if (BVALID && bready_q) begin
          bready_d     = 1'b0;
          code_d       = BRESP;
          resp_valid_d = 1'b1;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end else if (wd_fire_c) begin
          abort_c = 1'b1;
        end
      end

      S_RADDR: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end else if (wd_fire_c) begin
          abort_c = 1'b1;
        end
      end

      S_RDATA: begin
        if (RVALID && rready_q) begin
          rready_d = 1'b0;
          // error responses leave the last good load data in place
          if (!RRESP[1]) begin
            rdata_d = RDATA;
          end
          code_d       = RRESP;
          resp_valid_d = 1'b1;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end else if (wd_fire_c) begin
          abort_c = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase

    // Watchdog abort: drop every handshake line and report a local timeout
    if (abort_c) begin
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      aw_done_d    = 1'b0;
      w_done_d     = 1'b0;
      code_d       = CODE_TIMEOUT;
      resp_valid_d = 1'b1;
      timeout_d    = 1'b1;
      req_ready_d  = 1'b1;
      state_d      = S_IDLE;
    end

    // counter restarts on every state entry, runs while waiting on the bus
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (WD_EN && (state_q != S_IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      code_q       <= 2'b00;
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      code_q       <= code_d;
      resp_valid_q <= resp_valid_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_code  = code_q;
  assign timeout    = timeout_q;
  assign AWADDR     = addr_q;
  assign AWPROT     = PROT_VAL;
  assign AWVALID    = awvalid_q;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign WVALID     = wvalid_q;
  assign BREADY     = bready_q;
  assign ARADDR     = addr_q;
  assign ARPROT     = PROT_VAL;
  assign ARVALID    = arvalid_q;
  assign RREADY     = rready_q;

endmodule

// File: tb/tb_amba_memory_master.sv
// Directed bench for amba_memory_master with a hand-driven slave.
module tb_amba_memory_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              ACLK = 1'b0;
  logic              reset;
  logic              req_valid, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wstrb;
  logic              req_ready, resp_valid, timeout;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_code;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [2:0]        AWPROT, ARPROT;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic              ARVALID, ARREADY, RVALID, RREADY;

  int n_vec = 0;
  int n_err = 0;

  amba_memory_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8), .PROT_VAL(3'b000)
  ) dut (
    .ACLK(ACLK), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_code(resp_code),
    .timeout(timeout),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br,
                       input logic arr, input logic rv, input logic [31:0] rd, input logic [1:0] rr);
    AWREADY = awr; WREADY = wr; BVALID = bv; BRESP = br;
    ARREADY = arr; RVALID = rv; RDATA = rd; RRESP = rr;
  endtask

  task automatic request(input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = 4'hF;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    tick(); tick();

    // reset state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_awvalid",   32'(AWVALID),   32'd0);
    check("rst_arvalid",   32'(ARVALID),   32'd0);
    check("rst_resp_valid",32'(resp_valid),32'd0);
    check("rst_resp_code", 32'(resp_code), 32'd0);
    check("rst_rdata",     resp_rdata,     32'h0);
    check("rst_timeout",   32'(timeout),   32'd0);
    reset = 1'b1;
    tick();

    // 1: store, slave fully ready
    slave(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    request(1'b1, 32'd16, 32'hA5A5_0001);
    check("t1_awvalid",  32'(AWVALID), 32'd1);
    check("t1_wvalid",   32'(WVALID),  32'd1);
    check("t1_awaddr",   AWADDR,       32'd16);
    check("t1_wdata",    WDATA,        32'hA5A5_0001);
    check("t1_wstrb",    32'(WSTRB),   32'hF);
    check("t1_ready_lo", 32'(req_ready), 32'd0);
    tick();
    check("t1_aw_drop",  32'(AWVALID), 32'd0);
    check("t1_w_drop",   32'(WVALID),  32'd0);
    check("t1_bready",   32'(BREADY),  32'd1);
    check("t1_no_resp",  32'(resp_valid), 32'd0);
    tick();
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_resp_code",  32'(resp_code),  32'd0);
    check("t1_req_ready",  32'(req_ready),  32'd1);
    check("t1_bready_lo",  32'(BREADY),     32'd0);
    tick();
    check("t1_resp_pulse", 32'(resp_valid), 32'd0);

    // 2: load
    slave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_00FF, 2'b00);
    request(1'b0, 32'd15, 32'h0);
    check("t2_arvalid",  32'(ARVALID), 32'd1);
    check("t2_araddr",   ARADDR,       32'd15);
    check("t2_awvalid",  32'(AWVALID), 32'd0);
    tick();
    check("t2_ar_drop",  32'(ARVALID), 32'd0);
    check("t2_rready",   32'(RREADY),  32'd1);
    tick();
    check("t2_resp_valid", 32'(resp_valid), 32'd1);
    check("t2_rdata",      resp_rdata,      32'h0000_00FF);
    check("t2_code",       32'(resp_code),  32'd0);
    check("t2_rready_lo",  32'(RREADY),     32'd0);
    tick();
    check("t2_resp_pulse", 32'(resp_valid), 32'd0);
    check("t2_rdata_hold", resp_rdata,      32'h0000_00FF);

    // 3: SLVERR on store then on load
    slave(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 2'b00);
    request(1'b1, 32'd40, 32'h1234_5678);
    tick(); tick();
    check("t3w_resp_valid", 32'(resp_valid), 32'd1);
    check("t3w_code",       32'(resp_code),  32'd2);
    tick();
    slave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b10);
    request(1'b0, 32'd40, 32'h0);
    tick(); tick();
    check("t3r_resp_valid", 32'(resp_valid), 32'd1);
    check("t3r_code",       32'(resp_code),  32'd2);
    check("t3r_rdata_kept", resp_rdata,      32'h0000_00FF);
    tick();

    // 4: AWREADY two cycles ahead of WREADY
    slave(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    request(1'b1, 32'd24, 32'hCAFE_0004);
    check("t4_both_valid", 32'({AWVALID, WVALID}), 32'd3);
    tick();
    check("t4_aw_drop",  32'(AWVALID), 32'd0);
    check("t4_w_hold",   32'(WVALID),  32'd1);
    check("t4_wdata",    WDATA,        32'hCAFE_0004);
    AWREADY = 1'b0;
    tick();
    check("t4_w_hold2",  32'(WVALID),  32'd1);
    check("t4_aw_lo2",   32'(AWVALID), 32'd0);
    check("t4_bready_lo",32'(BREADY),  32'd0);
    WREADY = 1'b1;
    tick();
    check("t4_w_drop",   32'(WVALID),  32'd0);
    check("t4_bready",   32'(BREADY),  32'd1);
    tick();
    check("t4_resp_valid", 32'(resp_valid), 32'd1);
    check("t4_code",       32'(resp_code),  32'd0);
    tick();
    check("t4_single_b",   32'({resp_valid, BREADY}), 32'd0);

    // 5: no slave, watchdog of 8 cycles in WADDR
    slave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    request(1'b1, 32'd8, 32'h0000_0055);
    for (int i = 0; i < 7; i++) tick();
    check("t5_still_wait", 32'({AWVALID, WVALID}), 32'd3);
    check("t5_no_to_yet",  32'(timeout),           32'd0);
    check("t5_addr_stable",AWADDR,                 32'd8);
    tick();
    check("t5_valids_lo",  32'({AWVALID, WVALID}), 32'd0);
    check("t5_timeout",    32'(timeout),           32'd1);
    check("t5_resp_valid", 32'(resp_valid),        32'd1);
    check("t5_code",       32'(resp_code),         32'd3);
    check("t5_req_ready",  32'(req_ready),         32'd1);
    tick();
    check("t5_to_pulse",   32'({timeout, resp_valid}), 32'd0);

    // 6: reset while ARVALID is high
    request(1'b0, 32'd77, 32'h0);
    check("t6_arvalid",    32'(ARVALID),    32'd1);
    reset = 1'b0;
    tick();
    check("t6_ar_drop",    32'(ARVALID),    32'd0);
    check("t6_req_ready",  32'(req_ready),  32'd1);
    check("t6_no_resp",    32'(resp_valid), 32'd0);
    check("t6_code_clr",   32'(resp_code),  32'd0);
    reset = 1'b1;
    tick();
    check("t6_ar_stay_lo", 32'(ARVALID),    32'd0);
    check("t6_no_resp2",   32'(resp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
